// File: rtl/circuit_stim.sv
// LFSR stimulus source and response collector for the `circuit` datapath.
// Optional response signature enabled by macro CIRCUIT_STIM_SIG_EN (otherwise o_sig is tied to 0).
module circuit_stim #(
  parameter int          W     = 32,
  parameter int          DW    = 8,
  parameter int          NSAMP = 100,
  parameter int          LAT   = 1,
  parameter logic [31:0] SEED  = 32'h0000_0003
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_hold,
  output logic                 o_en,
  output logic signed [DW-1:0] o_in,
  input  logic [W-1:0]         i_y,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_count,
  output logic [W-1:0]         o_sig
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] POLY     = 32'hA300_0000;
  localparam int          DCW      = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          r_state;
  logic [31:0]     r_lfsr;
  logic            r_en;
  logic [DW-1:0]   r_in;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     r_count;
  logic [DCW-1:0]  r_dcnt;
  logic [LAT-1:0]  r_pipe;

  logic [31:0]     w_lfsr_next;
  logic [15:0]     w_count_inc;
  logic            w_last;
  logic            w_launch;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
  assign w_count_inc = r_count + 16'd1;
  assign w_last      = (w_count_inc == 16'(NSAMP));
  assign w_launch    = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_en    <= 1'b0;
      r_in    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_dcnt  <= '0;
      r_pipe  <= '0;
    end else begin
      // Shadow of en delayed by the DUT latency marks cycles where y is valid.
      r_pipe <= (r_pipe << 1) | LAT'(r_en);
      case (r_state)
        S_IDLE: begin
          r_en   <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (i_start) begin
            r_lfsr  <= SEED_EFF;
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_busy <= 1'b1;
          if (i_hold) begin
            r_en <= 1'b0;
          end else begin
            r_en    <= 1'b1;
            r_in    <= r_lfsr[DW-1:0];
            r_lfsr  <= w_lfsr_next;
            r_count <= w_count_inc;
            if (w_last) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_en   <= 1'b0;
          r_busy <= 1'b1;
          if (r_dcnt == DCW'(LAT - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end
        S_DONE: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CIRCUIT_STIM_SIG_EN
  logic [W-1:0] r_sig;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (w_launch) begin
      r_sig <= '0;
    end else if (r_pipe[LAT-1]) begin
      r_sig <= {r_sig[W-2:0], r_sig[W-1]} ^ i_y;
    end
  end

  assign o_sig = r_sig;
`else
  logic w_unused_y;
  assign w_unused_y = ^{i_y, w_launch};
  assign o_sig      = '0;
`endif

  assign o_en    = r_en;
  assign o_in    = r_in;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule

// File: tb/tb_circuit_stim.sv
// Directed bench for circuit_stim (NSAMP=3, LAT=1, SEED=3); a one-cycle model DUT returns in sign-extended.
module tb_circuit_stim;
  localparam int W = 32;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 hold;
  logic                 en;
  logic signed [DW-1:0] smp;
  logic [W-1:0]         y;
  logic                 busy;
  logic                 done;
  logic [15:0]          count;
  logic [W-1:0]         sig;

  int errors = 0;
  int checks = 0;

  logic        rec_en    [0:15];
  logic [7:0]  rec_in    [0:15];
  logic        rec_busy  [0:15];
  logic        rec_done  [0:15];
  logic [15:0] rec_count [0:15];

`ifdef CIRCUIT_STIM_SIG_EN
  localparam logic [W-1:0] SIG_EXP = 32'h0000_000E;
`else
  localparam logic [W-1:0] SIG_EXP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  // Stand-in for `circuit`: one-cycle latency, y = in sign-extended.
  always @(posedge clk) y <= {{(W-DW){smp[DW-1]}}, smp};

  circuit_stim #(.W(W), .DW(DW), .NSAMP(3), .LAT(1), .SEED(32'h0000_0003)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_hold(hold),
    .o_en(en), .o_in(smp), .i_y(y), .o_busy(busy), .o_done(done),
    .o_count(count), .o_sig(sig)
  );

  // Edge 0 samples start; hold is sampled at edges h_lo..h_hi; extra start pulses at s_a/s_b.
  task automatic run_record(input int ncyc, input int h_lo, input int h_hi, input int s_a, input int s_b);
    for (int e = 0; e < ncyc; e++) begin
      start = (e == 0) || (e == s_a) || (e == s_b);
      hold  = (e >= h_lo) && (e <= h_hi);
      @(posedge clk); #1;
      rec_en[e]    = en;
      rec_in[e]    = smp;
      rec_busy[e]  = busy;
      rec_done[e]  = done;
      rec_count[e] = count;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    #1;
    checks++; if (en !== 1'b0)     begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
    checks++; if (smp !== 8'h00)   begin errors++; $display("FAIL reset_in got=%h exp=00", smp); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (sig !== '0)      begin errors++; $display("FAIL reset_sig got=%h exp=0", sig); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_in [0:2];
    exp_in[0] = 8'h03; exp_in[1] = 8'h01; exp_in[2] = 8'h00;
    run_record(10, -1, -1, -1, -1);
    for (int e = 0; e < 10; e++) begin
      checks++; if (rec_en[e] !== (e >= 1 && e <= 3)) begin errors++; $display("FAIL basic_en e=%0d got=%b", e, rec_en[e]); end
      checks++; if (rec_busy[e] !== (e >= 1 && e <= 4)) begin errors++; $display("FAIL basic_busy e=%0d got=%b", e, rec_busy[e]); end
      checks++; if (rec_done[e] !== (e == 5)) begin errors++; $display("FAIL basic_done e=%0d got=%b", e, rec_done[e]); end
      if (e >= 1 && e <= 3) begin
        checks++; if (rec_in[e] !== exp_in[e-1]) begin errors++; $display("FAIL basic_in e=%0d got=%h exp=%h", e, rec_in[e], exp_in[e-1]); end
        checks++; if (rec_count[e] !== 16'(e)) begin errors++; $display("FAIL basic_count e=%0d got=%0d exp=%0d", e, rec_count[e], e); end
      end
    end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL basic_final_count got=%0d exp=3", count); end
    checks++; if (sig !== SIG_EXP) begin errors++; $display("FAIL basic_sig got=%h exp=%h", sig, SIG_EXP); end
  endtask

  task automatic test_hold();
    int n_en;
    n_en = 0;
    run_record(12, 3, 4, -1, -1);
    for (int e = 0; e < 12; e++) begin
      n_en += int'(rec_en[e]);
      checks++; if (rec_en[e] !== (e == 1 || e == 2 || e == 5)) begin errors++; $display("FAIL hold_en e=%0d got=%b", e, rec_en[e]); end
      checks++; if (rec_done[e] !== (e == 7)) begin errors++; $display("FAIL hold_done e=%0d got=%b", e, rec_done[e]); end
    end
    checks++; if (rec_in[3] !== 8'h01 || rec_in[4] !== 8'h01) begin errors++; $display("FAIL hold_in_stay got=%h,%h exp=01,01", rec_in[3], rec_in[4]); end
    checks++; if (rec_count[4] !== 16'd2) begin errors++; $display("FAIL hold_count_stay got=%0d exp=2", rec_count[4]); end
    checks++; if (rec_in[5] !== 8'h00) begin errors++; $display("FAIL hold_next_in got=%h exp=00", rec_in[5]); end
    checks++; if (n_en !== 3) begin errors++; $display("FAIL hold_total_en got=%0d exp=3", n_en); end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL hold_final_count got=%0d exp=3", count); end
    checks++; if (sig !== SIG_EXP) begin errors++; $display("FAIL hold_sig got=%h exp=%h", sig, SIG_EXP); end
  endtask

  task automatic test_start_with_hold();
    run_record(10, 0, 1, -1, -1);
    for (int e = 0; e < 10; e++) begin
      checks++; if (rec_en[e] !== (e >= 2 && e <= 4)) begin errors++; $display("FAIL sh_en e=%0d got=%b", e, rec_en[e]); end
      checks++; if (rec_busy[e] !== (e >= 1 && e <= 5)) begin errors++; $display("FAIL sh_busy e=%0d got=%b", e, rec_busy[e]); end
      checks++; if (rec_done[e] !== (e == 6)) begin errors++; $display("FAIL sh_done e=%0d got=%b", e, rec_done[e]); end
    end
    checks++; if (rec_in[2] !== 8'h03) begin errors++; $display("FAIL sh_first_in got=%h exp=03", rec_in[2]); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_in [0:2];
    exp_in[0] = 8'h03; exp_in[1] = 8'h01; exp_in[2] = 8'h00;
    run_record(10, -1, -1, 2, 5);
    for (int e = 0; e < 10; e++) begin
      checks++; if (rec_en[e] !== (e >= 1 && e <= 3)) begin errors++; $display("FAIL ign_en e=%0d got=%b", e, rec_en[e]); end
      checks++; if (rec_busy[e] !== (e >= 1 && e <= 4)) begin errors++; $display("FAIL ign_busy e=%0d got=%b", e, rec_busy[e]); end
      checks++; if (rec_done[e] !== (e == 5)) begin errors++; $display("FAIL ign_done e=%0d got=%b", e, rec_done[e]); end
      if (e >= 1 && e <= 3) begin
        checks++; if (rec_in[e] !== exp_in[e-1]) begin errors++; $display("FAIL ign_in e=%0d got=%h exp=%h", e, rec_in[e], exp_in[e-1]); end
      end
    end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL ign_count got=%0d exp=3", count); end
    checks++; if (sig !== SIG_EXP) begin errors++; $display("FAIL ign_sig got=%h exp=%h", sig, SIG_EXP); end
  endtask

  task automatic test_reset_midrun();
    run_record(3, -1, -1, -1, -1);
    checks++; if (rec_count[2] !== 16'd2) begin errors++; $display("FAIL mid_pre_count got=%0d exp=2", rec_count[2]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (en !== 1'b0)     begin errors++; $display("FAIL mid_en got=%b exp=0", en); end
    checks++; if (smp !== 8'h00)   begin errors++; $display("FAIL mid_in got=%h exp=00", smp); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (sig !== '0)      begin errors++; $display("FAIL mid_sig got=%h exp=0", sig); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || en !== 1'b0) begin errors++; $display("FAIL mid_quiet c=%0d done=%b busy=%b en=%b exp=0,0,0", c, done, busy, en); end
    end
    run_record(7, -1, -1, -1, -1);
    checks++; if (rec_en[1] !== 1'b1 || rec_in[1] !== 8'h03) begin errors++; $display("FAIL mid_restart en=%b in=%h exp=1,03", rec_en[1], rec_in[1]); end
    checks++; if (rec_done[5] !== 1'b1) begin errors++; $display("FAIL mid_restart_done got=%b exp=1", rec_done[5]); end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL mid_restart_count got=%0d exp=3", count); end
    checks++; if (sig !== SIG_EXP) begin errors++; $display("FAIL mid_restart_sig got=%h exp=%h", sig, SIG_EXP); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_with_hold();
    test_start_ignored();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
